// File: rtl/processing_array_cell.sv
// Smith-Waterman systolic cell: one query letter, scores one database beat per cycle.
// Define AFFINE_GAP_EN to add affine gap terms (in_gap/out_gap ports, internal F register).
module processing_array_cell #(
  parameter int unsigned SCORE_WIDTH  = 8,
  parameter int unsigned LETTER_WIDTH = 2,
  parameter int unsigned ROW_WIDTH    = 10,
  parameter int unsigned MATCH        = 1,
  parameter int unsigned MISMATCH     = 1,
  parameter int unsigned GAP_PENALTY  = 2,
  parameter int unsigned GAP_OPEN     = 3,
  parameter int unsigned GAP_EXTEND   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_query,
  input  logic [LETTER_WIDTH-1:0] query_letter,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [LETTER_WIDTH-1:0] in_letter,
  input  logic [SCORE_WIDTH-1:0]  in_score,
`ifdef AFFINE_GAP_EN
  input  logic [SCORE_WIDTH-1:0]  in_gap,
  output logic [SCORE_WIDTH-1:0]  out_gap,
`endif
  output logic                    out_valid,
  output logic                    out_last,
  output logic [LETTER_WIDTH-1:0] out_letter,
  output logic [SCORE_WIDTH-1:0]  out_score,
  output logic [1:0]              out_source,
  output logic                    out_zero,
  output logic [SCORE_WIDTH-1:0]  max_score,
  output logic [ROW_WIDTH-1:0]    max_row,
  output logic [1:0]              state
);

  localparam int unsigned SW1 = SCORE_WIDTH + 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Affine gap extension must never cost more than opening a gap.
  if (GAP_OPEN < GAP_EXTEND) begin : g_gap_cfg
    $error("GAP_OPEN must be >= GAP_EXTEND");
  end

  function automatic logic [SCORE_WIDTH-1:0] sub_clamp(input logic [SCORE_WIDTH-1:0] a,
                                                       input int unsigned b);
    logic [SW1-1:0] bw;
    logic [SW1-1:0] aw;
    bw = SW1'(b);
    aw = {1'b0, a};
    sub_clamp = (aw > bw) ? SCORE_WIDTH'(aw - bw) : '0;
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] add_sat(input logic [SCORE_WIDTH-1:0] a,
                                                     input int unsigned b);
    logic [SW1-1:0] sum;
    sum = {1'b0, a} + SW1'(b);
    add_sat = sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
  endfunction

  state_t                  cur_state, next_state;
  logic [LETTER_WIDTH-1:0] query;
  logic [SCORE_WIDTH-1:0]  diag, top;
  logic [ROW_WIDTH-1:0]    row;
  logic                    accept, clear, restart;
  logic [SCORE_WIDTH-1:0]  diag_op, top_op, max_op;
  logic [ROW_WIDTH-1:0]    row_op, max_row_op;
  logic [SCORE_WIDTH-1:0]  diag_term, top_term, left_term, h;
  logic [1:0]              src;
`ifdef AFFINE_GAP_EN
  logic [SCORE_WIDTH-1:0]  f_reg, f_op, e_term, f_term;
`endif

  assign state = cur_state;

  // Sequencing: loads win over beats outside RUN; a beat in DONE restarts the alignment.
  always_comb begin
    next_state = cur_state;
    accept     = 1'b0;
    clear      = 1'b0;
    restart    = 1'b0;
    case (cur_state)
      S_EMPTY: begin
        if (load_query) begin
          next_state = S_READY;
          clear      = 1'b1;
        end
      end
      S_READY, S_DONE: begin
        if (load_query) begin
          next_state = S_READY;
          clear      = 1'b1;
        end else if (in_valid) begin
          accept     = 1'b1;
          restart    = (cur_state == S_DONE);
          next_state = in_last ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_last) next_state = S_DONE;
        end
      end
      default: next_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_EMPTY;
    else     cur_state <= next_state;
  end

  // Score datapath; a restart sees cleared history for the beat that triggers it.
  always_comb begin
    diag_op    = restart ? '0 : diag;
    top_op     = restart ? '0 : top;
    max_op     = restart ? '0 : max_score;
    row_op     = restart ? '0 : row;
    max_row_op = restart ? '0 : max_row;
    diag_term  = (in_letter == query) ? add_sat(diag_op, MATCH) : sub_clamp(diag_op, MISMATCH);
`ifdef AFFINE_GAP_EN
    f_op      = restart ? '0 : f_reg;
    e_term    = sub_clamp(in_gap, GAP_EXTEND);
    if (sub_clamp(in_score, GAP_OPEN) > e_term) e_term = sub_clamp(in_score, GAP_OPEN);
    f_term    = sub_clamp(f_op, GAP_EXTEND);
    if (sub_clamp(top_op, GAP_OPEN) > f_term) f_term = sub_clamp(top_op, GAP_OPEN);
    top_term  = f_term;
    left_term = e_term;
`else
    top_term  = sub_clamp(top_op, GAP_PENALTY);
    left_term = sub_clamp(in_score, GAP_PENALTY);
`endif
    if (diag_term >= top_term && diag_term >= left_term) begin
      h   = diag_term;
      src = 2'b01;
    end else if (top_term >= left_term) begin
      h   = top_term;
      src = 2'b10;
    end else begin
      h   = left_term;
      src = 2'b11;
    end
    if (h == '0) src = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      query      <= '0;
      diag       <= '0;
      top        <= '0;
      row        <= '0;
      max_score  <= '0;
      max_row    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_letter <= '0;
      out_score  <= '0;
      out_source <= 2'b00;
      out_zero   <= 1'b0;
`ifdef AFFINE_GAP_EN
      f_reg      <= '0;
      out_gap    <= '0;
`endif
    end else begin
      out_valid  <= accept;
      out_last   <= accept & in_last;
      out_letter <= in_letter;
      if (clear) begin
        query     <= query_letter;
        diag      <= '0;
        top       <= '0;
        row       <= '0;
        max_score <= '0;
        max_row   <= '0;
`ifdef AFFINE_GAP_EN
        f_reg     <= '0;
        out_gap   <= '0;
`endif
      end else if (accept) begin
        diag       <= in_score;
        top        <= h;
        row        <= (row_op == '1) ? row_op : row_op + ROW_WIDTH'(1);
        out_score  <= h;
        out_source <= src;
        out_zero   <= (h == '0);
        // Strictly greater keeps the earliest row on ties.
        if (h > max_op) begin
          max_score <= h;
          max_row   <= row_op;
        end else begin
          max_score <= max_op;
          max_row   <= max_row_op;
        end
`ifdef AFFINE_GAP_EN
        f_reg      <= f_term;
        out_gap    <= e_term;
`endif
      end
    end
  end

endmodule

// File: tb/tb_processing_array_cell.sv
// Scoreboard bench for processing_array_cell (default build, default parameters).
module tb_processing_array_cell;

  localparam int SW = 8;
  localparam int LW = 2;
  localparam int RW = 10;
  localparam int SMAX = 255;
  localparam int RMAX = 1023;
  localparam int P_MATCH = 1;
  localparam int P_MISMATCH = 1;
  localparam int P_GAP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_query;
  logic [LW-1:0] query_letter;
  logic          in_valid, in_last;
  logic [LW-1:0] in_letter;
  logic [SW-1:0] in_score;
  logic          out_valid, out_last;
  logic [LW-1:0] out_letter;
  logic [SW-1:0] out_score;
  logic [1:0]    out_source;
  logic          out_zero;
  logic [SW-1:0] max_score;
  logic [RW-1:0] max_row;
  logic [1:0]    state;

  always #5 clk = ~clk;

  processing_array_cell dut (
    .clk(clk), .rst(rst), .load_query(load_query), .query_letter(query_letter),
    .in_valid(in_valid), .in_last(in_last), .in_letter(in_letter), .in_score(in_score),
    .out_valid(out_valid), .out_last(out_last), .out_letter(out_letter),
    .out_score(out_score), .out_source(out_source), .out_zero(out_zero),
    .max_score(max_score), .max_row(max_row), .state(state)
  );

  typedef struct {
    int score;
    int src;
    int mx;
    int mrow;
    int last;
    int letter;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  int m_state, m_query, m_diag, m_top, m_row, m_max, m_mrow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_diag = 0; m_top = 0; m_row = 0; m_max = 0; m_mrow = 0;
  endtask

  // Reference scoring: independent max-of-terms with equality-based source pick.
  task automatic model_beat(input int l, input int sc, input int last);
    int dt, tt, lt, h, src;
    exp_t e;
    if (l == m_query) dt = (m_diag + P_MATCH > SMAX) ? SMAX : m_diag + P_MATCH;
    else              dt = (m_diag > P_MISMATCH) ? m_diag - P_MISMATCH : 0;
    tt = (m_top > P_GAP) ? m_top - P_GAP : 0;
    lt = (sc > P_GAP) ? sc - P_GAP : 0;
    h = 0;
    if (dt > h) h = dt;
    if (tt > h) h = tt;
    if (lt > h) h = lt;
    if (h == 0)       src = 0;
    else if (dt == h) src = 1;
    else if (tt == h) src = 2;
    else              src = 3;
    if (h > m_max) begin
      m_max  = h;
      m_mrow = m_row;
    end
    m_row  = (m_row == RMAX) ? RMAX : m_row + 1;
    m_diag = sc;
    m_top  = h;
    e.score = h; e.src = src; e.mx = m_max; e.mrow = m_mrow; e.last = last; e.letter = l;
    sb.push_back(e);
  endtask

  // One clock of stimulus; the model decides acceptance and pushes expectations.
  task automatic cycle_in(input bit ld, input int ql, input bit v, input int l,
                          input int sc, input bit last);
    load_query   = ld;
    query_letter = LW'(ql);
    in_valid     = v;
    in_letter    = LW'(l);
    in_score     = SW'(sc);
    in_last      = last;
    case (m_state)
      0: if (ld) begin m_query = ql; model_clear(); m_state = 1; end
      1, 3: begin
        if (ld) begin
          m_query = ql; model_clear(); m_state = 1;
        end else if (v) begin
          if (m_state == 3) model_clear();
          model_beat(l, sc, int'(last));
          m_state = last ? 3 : 2;
        end
      end
      default: if (v) begin
        model_beat(l, sc, int'(last));
        if (last) m_state = 3;
      end
    endcase
    @(posedge clk);
    #1;
    load_query = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    check("state", 32'(state), 32'(m_state));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("out_score",  32'(out_score),  32'(e.score));
        check("out_source", 32'(out_source), 32'(e.src));
        check("out_zero",   32'(out_zero),   32'(e.score == 0));
        check("max_score",  32'(max_score),  32'(e.mx));
        check("max_row",    32'(max_row),    32'(e.mrow));
        check("out_last",   32'(out_last),   32'(e.last));
        check("out_letter", 32'(out_letter), 32'(e.letter));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_state"},     32'(state),      32'(0));
    check({tag, "_out_valid"}, 32'(out_valid),  32'(0));
    check({tag, "_out_score"}, 32'(out_score),  32'(0));
    check({tag, "_out_src"},   32'(out_source), 32'(0));
    check({tag, "_out_zero"},  32'(out_zero),   32'(0));
    check({tag, "_out_last"},  32'(out_last),   32'(0));
    check({tag, "_out_letter"}, 32'(out_letter), 32'(0));
    check({tag, "_max_score"}, 32'(max_score),  32'(0));
    check({tag, "_max_row"},   32'(max_row),    32'(0));
  endtask

  initial begin
    rst = 1'b1; load_query = 1'b0; query_letter = '0; in_valid = 1'b0;
    in_last = 1'b0; in_letter = '0; in_score = '0;
    m_state = 0; m_query = 0; model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    cycle_in(1, 0, 0, 0, 0, 0);
    cycle_in(0, 0, 1, 0, 0, 0);
    check("first_score", 32'(out_score), 32'(1));
    check("first_src",   32'(out_source), 32'(1));
    check("first_max",   32'(max_score), 32'(1));
    check("first_row",   32'(max_row), 32'(0));
    cycle_in(0, 0, 1, 1, 3, 0);
    check("left_score", 32'(out_score), 32'(1));
    check("left_src",   32'(out_source), 32'(3));
    check("tie_max",    32'(max_score), 32'(1));
    check("tie_row",    32'(max_row), 32'(0));
    cycle_in(0, 0, 1, 1, 255, 0);
    cycle_in(0, 0, 1, 0, 0, 0);
    check("sat_score", 32'(out_score), 32'(255));
    check("sat_src",   32'(out_source), 32'(1));
    check("sat_row",   32'(max_row), 32'(3));
    cycle_in(0, 0, 1, 1, 10, 1);
    check("done_state", 32'(state), 32'(3));
    cycle_in(0, 0, 1, 0, 0, 0);
    check("restart_max", 32'(max_score), 32'(1));
    check("restart_row", 32'(max_row), 32'(0));

    for (int i = 0; i < 80; i++) begin
      cycle_in(($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 255)), ($urandom_range(0, 11) == 0));
    end

    cycle_in(0, 0, 1, 1, 7, 1);
    cycle_in(1, 2, 1, 2, 9, 0);
    check("load_drops_beat", 32'(out_valid), 32'(0));
    check("load_to_ready",   32'(state), 32'(1));

    for (int i = 0; i < 1030; i++) cycle_in(0, 0, 1, 0, 0, 0);
    check("zero_flag", 32'(out_zero), 32'(1));
    cycle_in(0, 0, 1, 0, 100, 0);
    check("row_sat_max", 32'(max_score), 32'(98));
    check("row_sat_row", 32'(max_row), 32'(RMAX));

    cycle_in(1, 1, 1, 1, 50, 0);
    check("run_ignores_load", 32'(state), 32'(2));
    rst = 1'b1; in_valid = 1'b1; in_letter = LW'(1); in_score = SW'(20);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    m_state = 0; m_query = 0; model_clear();
    check_all_zero("mid_reset");
    cycle_in(0, 0, 1, 1, 40, 0);
    check("empty_ignores_beat", 32'(out_valid), 32'(0));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/processing_array_cell.md
PROCESSING_ARRAY_CELL -- requirements
Module: processing_array_cell

Interface
REQ-001 Parameter SCORE_WIDTH, default 8: width of every score bus and of max_score.
REQ-002 Parameter LETTER_WIDTH, default 2: width of query and database letters.
REQ-003 Parameter ROW_WIDTH, default 10: width of the row counter and max_row.
REQ-004 Parameters MATCH, default 1, MISMATCH, default 1, GAP_PENALTY, default 2: unsigned scoring constants.
REQ-005 Parameters GAP_OPEN, default 3, GAP_EXTEND, default 1: used only under AFFINE_GAP_EN.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 load_query  input  1  one-cycle strobe; capture query_letter.
REQ-009 query_letter  input  LETTER_WIDTH  query letter owned by this cell.
REQ-010 in_valid, in_last  input  1 each  database beat valid; final beat of the sequence.
REQ-011 in_letter  input  LETTER_WIDTH  database letter from the upstream cell.
REQ-012 in_score  input  SCORE_WIDTH  upstream H(i,j-1), the left score.
REQ-013 out_valid, out_last  output  1 each  registered copies of in_valid and in_last.
REQ-014 out_letter  output  LETTER_WIDTH  in_letter delayed one cycle.
REQ-015 out_score  output  SCORE_WIDTH  this cell's H(i,j).
REQ-016 out_source  output  2  H origin: 00 zero, 01 diagonal, 10 top, 11 left.
REQ-017 out_zero  output  1  high when out_score equals 0.
REQ-018 max_score, max_row  output  SCORE_WIDTH, ROW_WIDTH  best H of the current alignment and the row it occurred on.
REQ-019 state  output  2  00 EMPTY, 01 READY, 10 RUN, 11 DONE.

Function
REQ-020 When in_valid is accepted, the cell computes H = max(0, diag+s, top-GAP_PENALTY, left-GAP_PENALTY), with s=+MATCH when letters are equal and -MISMATCH otherwise.
REQ-021 Operand roles: left = in_score; diag = in_score captured on the previous accepted beat; top = this cell's previous H.
REQ-022 Subtractions clamp at 0 and additions saturate at 2^SCORE_WIDTH-1; there is no wrap.
REQ-023 Source tie-break priority is diagonal > top > left; out_source is 00 whenever H = 0.
REQ-024 Latency is exactly 1 cycle from an accepted beat to out_valid, with all out_* signals registered.
REQ-025 A beat with in_valid low leaves out_valid low and holds diag, top and the row counter unchanged.
REQ-026 EMPTY -> READY on load_query, which also clears diag, top, max_score, max_row and the row counter.
REQ-027 READY -> RUN on the first accepted beat.
REQ-028 RUN -> DONE on an accepted beat with in_last high; that beat is still computed and forwarded.
REQ-029 DONE -> READY on load_query.
REQ-030 DONE -> RUN on in_valid without load_query; this restarts with the same query, clearing diag, top, max and the row counter before computing the beat.
REQ-031 In EMPTY, in_valid is ignored and out_valid stays 0.
REQ-032 In RUN, load_query is ignored.
REQ-033 In READY or DONE, when load_query and in_valid are high together, the load takes effect and the beat is dropped.
REQ-034 The row counter increments per accepted beat and saturates at 2^ROW_WIDTH-1.
REQ-035 max_score and max_row update only on strictly greater H, so the earliest row wins ties.

Reset
REQ-036 Reset forces state EMPTY and clears the query letter, diag, top, the row counter and every output to 0.
REQ-037 Reset asserted mid-RUN aborts the alignment with no out_valid on the following cycle.

Configuration
REQ-038 When AFFINE_GAP_EN is defined, the cell adds in_gap (input) and out_gap (output) ports of SCORE_WIDTH, plus an internal F register.
REQ-039 Under AFFINE_GAP_EN, the gap terms are E = max(in_gap-GAP_EXTEND, left-GAP_OPEN), output on out_gap, and F = max(F_prev-GAP_EXTEND, top-GAP_OPEN).
REQ-040 Under AFFINE_GAP_EN, H = max(0, diag+s, F, E), with F taking the top source code and E the left source code; E and F reset and clear like top.
REQ-041 Without AFFINE_GAP_EN, in_gap and out_gap do not exist and GAP_OPEN and GAP_EXTEND are unused.

Verification
REQ-042 Defaults: load_query with query 00, then beat in_letter 00, in_score 0 -> next cycle out_score 1, out_source 01, max_score 1, max_row 0.
REQ-043 Continue with beat in_letter 01, in_score 3 -> out_score 1, out_source 11, max_score still 1, max_row still 0.
REQ-044 Beat in_score 255 with a mismatch, then a match beat -> diag term saturates and out_score is 255.
REQ-045 Beat with in_last set -> state DONE; the next in_valid without load_query -> row counter and max_score restart from 0.
REQ-046 Reset asserted during RUN -> state EMPTY, all outputs 0, and a following in_valid produces no out_valid.
REQ-047 AFFINE_GAP_EN: in_gap 5, in_score 4, mismatch, top 0 -> out_gap 4 and out_score 4 with out_source 11.
